// File: rtl/axi_pkg.sv
// Shared AXI read-path definitions: field widths, encodings and arbiter states.
package axi_pkg;

  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin pick: the first requester strictly after
// ptr (wrapping) wins; result is one-hot, or zero when nobody requests.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan ptr+1, ptr+2, ... ptr+N (mod N) and keep the first hit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one slave AR/R read path between NUM_MASTERS
// requesters, one outstanding burst at a time.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner; pick a winner from pending ARVALIDs
//   ST_ADDR | owner's AR channel routed to the slave until handshake
//   ST_DATA | slave R channel routed to owner until the RLAST handshake
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_MASTERS        = 2,
  parameter int ADDR_WIDTH         = 32,
  parameter int READ_CHANNEL_WIDTH = 32,
  parameter int READ_BURST_LEN     = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_MASTERS-1:0]                m_ARVALID,
  output logic [NUM_MASTERS-1:0]                m_ARREADY,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_ARADDR,
  input  logic [NUM_MASTERS*READ_BURST_LEN-1:0] m_ARLEN,
  input  logic [NUM_MASTERS*AXI_SIZE_W-1:0]     m_ARSIZE,
  input  logic [NUM_MASTERS*AXI_BURST_W-1:0]    m_ARBURST,
  output logic [NUM_MASTERS-1:0]                m_RVALID,
  output logic [READ_CHANNEL_WIDTH-1:0]         m_RDATA,
  output logic                                  m_RLAST,
  output logic [AXI_RESP_W-1:0]                 m_RRESP,
  input  logic [NUM_MASTERS-1:0]                m_RREADY,
  output logic                                  ARVALID,
  input  logic                                  ARREADY,
  output logic [ADDR_WIDTH-1:0]                 ARADDR,
  output logic [READ_BURST_LEN-1:0]             ARLEN,
  output logic [AXI_SIZE_W-1:0]                 ARSIZE,
  output logic [AXI_BURST_W-1:0]                ARBURST,
  input  logic                                  RVALID,
  input  logic [READ_CHANNEL_WIDTH-1:0]         RDATA,
  input  logic                                  RLAST,
  input  logic [AXI_RESP_W-1:0]                 RRESP,
  output logic                                  RREADY,
  output logic [NUM_MASTERS-1:0]                grant,
  output logic                                  rlast_err
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e                state_q, state_d;
  logic [NUM_MASTERS-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [READ_BURST_LEN-1:0] len_q, len_d;
  logic [READ_BURST_LEN-1:0] cnt_q, cnt_d;
  logic                      rlast_err_q, rlast_err_d;

  logic [NUM_MASTERS-1:0]    winner;
  logic [READ_BURST_LEN-1:0] win_len;
  logic [PTR_W-1:0]          g_idx;
  logic                      sel_arvalid;
  logic                      sel_rready;
  logic [ADDR_WIDTH-1:0]     sel_araddr;
  logic [READ_BURST_LEN-1:0] sel_arlen;
  logic [AXI_SIZE_W-1:0]     sel_arsize;
  logic [AXI_BURST_W-1:0]    sel_arburst;

  rr_arbiter #(
    .N    (NUM_MASTERS),
    .PTR_W(PTR_W)
  ) u_rr (
    .req(m_ARVALID),
    .ptr(ptr_q),
    .gnt(winner)
  );

  // State registers; pointer resets to the last master so master 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= PTR_W'(NUM_MASTERS - 1);
      len_q       <= '0;
      cnt_q       <= '0;
      rlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rlast_err_q <= rlast_err_d;
    end
  end

  // One-hot muxes: owner's AR fields and RREADY, plus the new winner's ARLEN.
  always_comb begin
    sel_arvalid = 1'b0;
    sel_rready  = 1'b0;
    sel_araddr  = '0;
    sel_arlen   = '0;
    sel_arsize  = '0;
    sel_arburst = '0;
    g_idx       = '0;
    win_len     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        sel_arvalid = m_ARVALID[i];
        sel_rready  = m_RREADY[i];
        sel_araddr  = m_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_arlen   = m_ARLEN[i*READ_BURST_LEN +: READ_BURST_LEN];
        sel_arsize  = m_ARSIZE[i*AXI_SIZE_W +: AXI_SIZE_W];
        sel_arburst = m_ARBURST[i*AXI_BURST_W +: AXI_BURST_W];
        g_idx       = PTR_W'(i);
      end
      if (winner[i]) begin
        win_len = m_ARLEN[i*READ_BURST_LEN +: READ_BURST_LEN];
      end
    end
  end

  // Handshake routing: only the owner ever sees ARREADY/RVALID.
  always_comb begin
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    m_ARREADY = '0;
    m_RVALID  = '0;
    case (state_q)
      ST_ADDR: begin
        ARVALID   = sel_arvalid;
        m_ARREADY = grant_q & {NUM_MASTERS{ARREADY}};
      end
      ST_DATA: begin
        RREADY   = sel_rready;
        m_RVALID = grant_q & {NUM_MASTERS{RVALID}};
      end
      default: ;
    endcase
  end

  // Next state. The grant is never revoked in ADDR even if the owner drops
  // ARVALID. rlast_err flags RLAST arriving on any beat other than len_q,
  // and its absence on beat len_q.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rlast_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|m_ARVALID) begin
          grant_d = winner;
          len_d   = win_len;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ARVALID && ARREADY) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (RVALID && RREADY) begin
          cnt_d = cnt_q + READ_BURST_LEN'(1);
          if (RLAST) begin
            rlast_err_d = (cnt_q != len_q);
            ptr_d       = g_idx;
            grant_d     = '0;
            state_d     = ST_IDLE;
          end else begin
            rlast_err_d = (cnt_q == len_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ARADDR    = sel_araddr;
  assign ARLEN     = sel_arlen;
  assign ARSIZE    = sel_arsize;
  assign ARBURST   = sel_arburst;
  assign m_RDATA   = RDATA;
  assign m_RLAST   = RLAST;
  assign m_RRESP   = RRESP;
  assign grant     = grant_q;
  assign rlast_err = rlast_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: master agents, a slave responder, a burst-level
// reference model compared every cycle, and directed scenarios.
module tb_axi_read_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    m_ARVALID, m_ARREADY, m_RVALID, m_RREADY, grant;
  logic [N*AW-1:0] m_ARADDR;
  logic [N*LW-1:0] m_ARLEN;
  logic [N*3-1:0]  m_ARSIZE;
  logic [N*2-1:0]  m_ARBURST;
  logic [DW-1:0]   m_RDATA, RDATA;
  logic [1:0]      m_RRESP, RRESP, ARBURST;
  logic            m_RLAST, ARVALID, ARREADY, RVALID, RLAST, RREADY, rlast_err;
  logic [AW-1:0]   ARADDR;
  logic [LW-1:0]   ARLEN;
  logic [2:0]      ARSIZE;

  always #5 clk = ~clk;

  axi_read_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(DW), .READ_BURST_LEN(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN),
    .m_ARSIZE(m_ARSIZE), .m_ARBURST(m_ARBURST), .m_RVALID(m_RVALID), .m_RDATA(m_RDATA),
    .m_RLAST(m_RLAST), .m_RRESP(m_RRESP), .m_RREADY(m_RREADY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .RVALID(RVALID), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
    .RREADY(RREADY), .grant(grant), .rlast_err(rlast_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- master agents: issued requests vs accepted AR handshakes
  int            issued[N]   = '{default: 0};
  int            accepted[N] = '{default: 0};
  int            mark[N]     = '{default: 0};
  logic [AW-1:0] base[N]     = '{default: '0};
  logic [AW-1:0] stride[N]   = '{default: '0};
  logic [LW-1:0] len_cfg[N]  = '{default: '0};

  for (genvar i = 0; i < N; i++) begin : g_m
    assign m_ARVALID[i]          = issued[i] > accepted[i];
    assign m_ARADDR[i*AW +: AW]  = base[i] + stride[i] * AW'(accepted[i] - mark[i]);
    assign m_ARLEN[i*LW +: LW]   = len_cfg[i];
    assign m_ARSIZE[i*3 +: 3]    = 3'd2;
    assign m_ARBURST[i*2 +: 2]   = 2'b01;
  end

  // values sampled at the falling edge, consumed at the next rising edge
  logic [N-1:0]    s_mvalid, s_mrready, s_mhs;
  logic [N*LW-1:0] s_arlens;
  logic            s_arready, s_rvalid, s_rlast, s_arhs, s_rhs;
  logic [AW-1:0]   s_araddr;
  logic [LW-1:0]   s_arlen;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) if (s_mhs[i]) accepted[i] <= accepted[i] + 1;
  end

  // ---------------- slave responder: data = address + beat index
  int            s_len_q[$];
  logic [AW-1:0] s_addr_q[$];
  logic [AW-1:0] ar_log[$];
  int            sbeat = 0;
  int            s_ovr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_len_q.delete(); s_addr_q.delete(); sbeat = 0;
      RVALID <= 1'b0; RLAST <= 1'b0; RDATA <= '0; RRESP <= '0;
    end else begin
      if (s_rhs) begin
        if (s_rlast) begin
          void'(s_len_q.pop_front()); void'(s_addr_q.pop_front()); sbeat = 0;
        end else sbeat++;
      end
      if (s_arhs) begin
        s_len_q.push_back(s_ovr != 0 ? s_ovr : int'(s_arlen) + 1);
        s_addr_q.push_back(s_araddr);
        ar_log.push_back(s_araddr);
      end
      if (s_len_q.size() > 0) begin
        RVALID <= 1'b1;
        RLAST  <= (sbeat == s_len_q[0] - 1);
        RDATA  <= s_addr_q[0] + DW'(sbeat);
        RRESP  <= 2'(sbeat);
      end else begin
        RVALID <= 1'b0; RLAST <= 1'b0;
      end
    end
  end

  // ---------------- reference model: who owns the bus and in which phase
  int md_owner = -1;   // -1: nobody
  bit md_addr  = 0;    // owner still presenting its address
  int md_ptr   = N - 1;
  int md_len   = 0;    // burst is md_len+1 beats
  int md_done  = 0;    // beats delivered so far
  bit md_err   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_owner = -1; md_addr = 0; md_ptr = N - 1; md_len = 0; md_done = 0; md_err = 0;
    end else begin
      md_err = 0;
      if (md_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (md_owner < 0 && s_mvalid[(md_ptr + k) % N]) begin
            md_owner = (md_ptr + k) % N;
            md_addr  = 1;
            md_len   = int'(s_arlens[md_owner*LW +: LW]);
          end
        end
      end else if (md_addr) begin
        if (s_mvalid[md_owner] && s_arready) begin md_addr = 0; md_done = 0; end
      end else if (s_rvalid && s_mrready[md_owner]) begin
        if (s_rlast) begin
          md_err   = (md_done + 1 != md_len + 1);
          md_ptr   = md_owner;
          md_owner = -1;
        end else begin
          md_err  = (md_done + 1 == md_len + 1);
          md_done = (md_done + 1) % 256;
        end
      end
    end
  end

  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    if (i >= 0) oh[i] = 1'b1;
  endfunction

  // ---------------- per-cycle compare and bookkeeping
  int            beats[N] = '{default: 0};
  int            last_cyc[N] = '{default: 0};
  int            err_cnt = 0, err_cyc = 0, stall0 = 0, viol1 = 0;
  int            t_last0 = 0, t_ar1 = 0;
  bit            seen_last0 = 0, seen_ar1 = 0, prev_stall0 = 0;
  logic [DW-1:0] prev_rdata = '0;
  logic [N-1:0]  prev_grant = '0;
  logic [N-1:0]  grant_log[$];
  logic [DW-1:0] rx0[$];
  logic [N-1:0]  e_grant, e_marr, e_mrv;
  logic          e_arv, e_rr;

  always @(negedge clk) begin
    cyc++;
    s_mvalid = m_ARVALID; s_mrready = m_RREADY; s_arlens = m_ARLEN; s_arready = ARREADY;
    s_rvalid = RVALID; s_rlast = RLAST; s_arhs = ARVALID && ARREADY; s_rhs = RVALID && RREADY;
    s_araddr = ARADDR; s_arlen = ARLEN; s_mhs = m_ARVALID & m_ARREADY;

    e_grant = oh(md_owner);
    e_arv   = (md_owner >= 0) && md_addr && m_ARVALID[md_owner];
    e_marr  = ((md_owner >= 0) && md_addr && ARREADY) ? oh(md_owner) : '0;
    e_mrv   = ((md_owner >= 0) && !md_addr && RVALID) ? oh(md_owner) : '0;
    e_rr    = (md_owner >= 0) && !md_addr && m_RREADY[md_owner];
    chk("grant", grant, e_grant);
    chk("ARVALID", ARVALID, e_arv);
    chk("m_ARREADY", m_ARREADY, e_marr);
    chk("m_RVALID", m_RVALID, e_mrv);
    chk("RREADY", RREADY, e_rr);
    chk("rlast_err", rlast_err, md_err);
    chk("m_RDATA", m_RDATA, RDATA);
    chk("m_RLAST", m_RLAST, RLAST);
    chk("m_RRESP", m_RRESP, RRESP);
    if (e_arv) begin
      chk("ARADDR", ARADDR, m_ARADDR[md_owner*AW +: AW]);
      chk("ARLEN", ARLEN, m_ARLEN[md_owner*LW +: LW]);
      chk("ARSIZE", ARSIZE, m_ARSIZE[md_owner*3 +: 3]);
    end
    if (prev_stall0 && m_RVALID[0]) chk("rdata_hold", m_RDATA, prev_rdata);

    for (int i = 0; i < N; i++) begin
      if (m_RVALID[i] && m_RREADY[i]) begin
        beats[i]++;
        if (i == 0) rx0.push_back(m_RDATA);
        if (m_RLAST) last_cyc[i] = cyc;
        if (i == 0 && m_RLAST && !seen_last0) begin t_last0 = cyc; seen_last0 = 1; end
      end
    end
    if (ARVALID && grant == 2'b10 && !seen_ar1) begin t_ar1 = cyc; seen_ar1 = 1; end
    if (rlast_err) begin err_cnt++; err_cyc = cyc; end
    if (m_RVALID[0] && !m_RREADY[0]) stall0++;
    if (m_ARREADY[1] && grant[0]) viol1++;
    if (grant != prev_grant && grant != '0) grant_log.push_back(grant);
    prev_grant  = grant;
    prev_stall0 = m_RVALID[0] && !m_RREADY[0];
    prev_rdata  = m_RDATA;
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (issued[i] != accepted[i]) return 1'b1;
    return (grant != '0) || RVALID || (s_len_q.size() != 0);
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy() && n < 600) begin tick(); n++; end
    chk(nm, n < 600, 1'b1);
    tick(); tick();
  endtask

  task automatic setup(input int m, input logic [AW-1:0] b, input logic [AW-1:0] st, input logic [LW-1:0] l);
    base[m] = b; stride[m] = st; len_cfg[m] = l; mark[m] = accepted[m];
  endtask

  int b0, b1, gl, al, ri, e0, st0, n;

  initial begin
    ARREADY = 1'b1;
    m_RREADY = '1;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_err", rlast_err, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    // both masters request together, ARLEN=3
    setup(0, 32'h100, 32'h10, 8'd3); setup(1, 32'h200, 32'h10, 8'd3);
    gl = grant_log.size(); al = ar_log.size(); b0 = beats[0]; b1 = beats[1];
    issued[0]++; issued[1]++;
    wait_idle("t1_timeout");
    chk("t1_first_grant", grant_log[gl], 2'b01);
    chk("t1_second_grant", grant_log[gl+1], 2'b10);
    chk("t1_beats0", beats[0] - b0, 4);
    chk("t1_beats1", beats[1] - b1, 4);
    chk("t1_addr0", ar_log[al], 32'h100);
    chk("t1_addr1", ar_log[al+1], 32'h200);
    chk("t1_rearb_gap", t_ar1 - t_last0, 2);

    // master 0 alone, three back-to-back 8-beat bursts
    setup(0, 32'h0, 32'h20, 8'd7);
    al = ar_log.size(); b0 = beats[0]; b1 = beats[1];
    issued[0] += 3;
    wait_idle("t2_timeout");
    chk("t2_bursts", ar_log.size() - al, 3);
    chk("t2_addr_a", ar_log[al], 32'h00);
    chk("t2_addr_b", ar_log[al+1], 32'h20);
    chk("t2_addr_c", ar_log[al+2], 32'h40);
    chk("t2_beats0", beats[0] - b0, 24);
    chk("t2_beats1", beats[1] - b1, 0);

    // master 1 requests while master 0 is mid-burst
    setup(0, 32'h1000, 32'h20, 8'd7); setup(1, 32'h2000, 32'h10, 8'd3);
    gl = grant_log.size();
    issued[0]++;
    n = 0;
    while (!m_RVALID[0] && n < 50) begin tick(); n++; end
    chk("t3_data_timeout", n < 50, 1'b1);
    issued[1]++;
    wait_idle("t3_timeout");
    chk("t3_owner_first", grant_log[gl], 2'b01);
    chk("t3_owner_next", grant_log[gl+1], 2'b10);
    chk("t3_no_early_ready", viol1, 0);

    // backpressure on master 0's RREADY
    setup(0, 32'h3000, 32'h10, 8'd3);
    ri = rx0.size(); b0 = beats[0]; st0 = stall0;
    issued[0]++;
    n = 0;
    while (busy() && n < 60) begin m_RREADY[0] = ~m_RREADY[0]; tick(); n++; end
    m_RREADY[0] = 1'b1;
    chk("t4_timeout", n < 60, 1'b1);
    tick(); tick();
    chk("t4_beats", beats[0] - b0, 4);
    chk("t4_stalled", stall0 > st0, 1'b1);
    for (int k = 0; k < 4; k++) chk("t4_data", rx0[ri+k], 32'h3000 + 32'(k));

    // RLAST on beat 2 of a 4-beat burst
    setup(0, 32'h4000, 32'h10, 8'd3);
    s_ovr = 2; e0 = err_cnt; b0 = beats[0];
    issued[0]++;
    wait_idle("t5a_timeout");
    chk("t5a_err_pulses", err_cnt - e0, 1);
    chk("t5a_err_timing", err_cyc - last_cyc[0], 1);
    chk("t5a_beats", beats[0] - b0, 2);
    chk("t5a_idle", grant, 0);

    // RLAST missing on beat 4, arrives on beat 5: both beats are flagged
    s_ovr = 5; e0 = err_cnt; b0 = beats[0];
    issued[0]++;
    wait_idle("t5b_timeout");
    chk("t5b_err_pulses", err_cnt - e0, 2);
    chk("t5b_beats", beats[0] - b0, 5);
    s_ovr = 0;

    // asynchronous reset in the middle of a data burst
    setup(1, 32'h5000, 32'h10, 8'd7);
    b1 = beats[1];
    issued[1]++;
    n = 0;
    while (beats[1] - b1 < 2 && n < 50) begin tick(); n++; end
    chk("t6_data_timeout", n < 50, 1'b1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_arvalid", ARVALID, 0);
    chk("t6_rready", RREADY, 0);
    chk("t6_rvalid", m_RVALID, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    setup(0, 32'h6000, 32'h10, 8'd1); setup(1, 32'h7000, 32'h10, 8'd1);
    gl = grant_log.size();
    issued[0]++; issued[1]++;
    wait_idle("t6_timeout");
    chk("t6_first_after_rst", grant_log[gl], 2'b01);
    chk("t6_second_after_rst", grant_log[gl+1], 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the read path (AR/R channels) of one axi_slave between NUM_MASTERS requesters, e.g. instruction fetch and data cache.
- Round-robin arbitration, one outstanding burst at a time.
- The grant is held from AR handshake until the last R beat.
- Sits between the CPU-side masters and the axi_slave read ports. The write channels bypass this block.

Parameters:
- NUM_MASTERS, 2, number of requesters (N ≥ 2).
- ADDR_WIDTH, 32, ARADDR width.
- READ_CHANNEL_WIDTH, 32, RDATA width.
- READ_BURST_LEN, 8, ARLEN width in bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- m_ARVALID  in  N  per-master address valid
- m_ARREADY  out  N  per-master address ready
- m_ARADDR  in  N*ADDR_WIDTH  flattened, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_ARLEN  in  N*READ_BURST_LEN  flattened burst lengths
- m_ARSIZE  in  N*3  flattened sizes
- m_ARBURST  in  N*2  flattened burst types
- m_RVALID  out  N  per-master data valid
- m_RDATA  out  READ_CHANNEL_WIDTH  broadcast read data
- m_RLAST  out  1  broadcast last beat
- m_RRESP  out  2  broadcast response
- m_RREADY  in  N  per-master data ready
- ARVALID  out  1  to slave
- ARREADY  in  1  from slave
- ARADDR  out  ADDR_WIDTH  to slave
- ARLEN  out  READ_BURST_LEN  to slave
- ARSIZE  out  3  to slave
- ARBURST  out  2  to slave
- RVALID  in  1  from slave
- RDATA  in  READ_CHANNEL_WIDTH  from slave
- RLAST  in  1  from slave
- RRESP  in  2  from slave
- RREADY  out  1  to slave
- grant  out  N  one-hot current owner, 0 in IDLE
- rlast_err  out  1  one-cycle pulse on beat-count mismatch

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0, beat counter=0, rlast_err=0.
  - RR pointer = N-1, so master 0 wins first.
  - All outputs held at 0: ARVALID, RREADY, m_ARREADY, m_RVALID.
- Reset mid-burst: abandons the burst immediately; in-flight slave beats are not drained.
- State IDLE:
  - If any m_ARVALID is set, select the first requester scanning from pointer+1 upward (mod N).
  - Register grant one-hot, latch ARLEN of the winner into len_q, go to ADDR.
  - Outputs in IDLE: ARVALID=0, RREADY=0, all m_ARREADY=0.
- State ADDR:
  - Combinational mux by registered grant: ARVALID=m_ARVALID[g], ARADDR/LEN/SIZE/BURST from master g, m_ARREADY[g]=ARREADY.
  - Other m_ARREADY bits are 0.
  - On ARVALID&ARREADY: go to DATA, clear the beat counter.
  - If master g drops ARVALID (protocol violation), stay in ADDR; the grant is never revoked.
- State DATA:
  - m_RVALID[g]=RVALID, RREADY=m_RREADY[g]; other m_RVALID bits are 0.
  - m_RDATA/m_RLAST/m_RRESP are RDATA/RLAST/RRESP passed through combinationally.
  - Each RVALID&RREADY increments the beat counter; width is READ_BURST_LEN and it wraps silently.
  - On a handshake with RLAST=1: pointer=g, grant=0, go to IDLE.
  - rlast_err pulses the cycle after the last beat if count≠len_q. It also pulses the cycle after a non-last beat when count==len_q (RLAST missing).
- Latency:
  - Request seen in IDLE at cycle t → ARVALID to the slave at t+1.
  - After an RLAST handshake at t, the next ARVALID is at t+2 (one IDLE bubble).
- Simultaneous requests: the RR pointer decides. A master that requests continuously gets at most one burst per N arbitration rounds while others are waiting.
- Non-owners see ARREADY=0 and RVALID=0 throughout a burst and must hold their requests.

Decomposition:
- Shared package axi_pkg: ARSIZE/ARBURST/RRESP widths, burst-type and RRESP constants (OKAY=2'b00), state encodings IDLE/ADDR/DATA.
- One sub-module rr_arbiter: combinational N-way round-robin pick taking a request vector and pointer, returning a one-hot winner. Reusable for a future write-channel arbiter.

Test Plan:
- Reset then m_ARVALID=2'b11, both ARLEN=3:
  - Master 0 is granted first (grant=01), 4 beats routed only to m_RVALID[0].
  - Then master 1 (grant=10), ARVALID re-asserted 2 cycles after RLAST.
- Master 0 alone issues 3 back-to-back bursts (ARADDR 0x00, 0x20, 0x40, ARLEN=7) → 3×8 beats, no beats on m_RVALID[1].
- Master 1 asserts ARVALID while master 0 is mid-burst → master 1's m_ARREADY stays 0 until master 0's RLAST; master 1 wins the next round.
- Backpressure: m_RREADY[0] toggles 1,0,1,0 during an ARLEN=3 burst → RREADY mirrors it, RDATA held while stalled, exactly 4 beats accepted.
- Slave asserts RLAST on beat 2 of an ARLEN=3 burst → rlast_err=1 for one cycle and the FSM returns to IDLE. Separately, RLAST missing on beat 4 → rlast_err pulses.
- rst_n=0 asserted mid-DATA → grant=0, ARVALID=0, RREADY=0 immediately (asynchronous); after release, master 0 has priority.
